// File: rtl/pattern_gen_pkg.sv
// Shared mode encodings and pattern helpers for the LED pattern generator.
package pattern_gen_pkg;

    localparam logic [2:0] MODE_UP      = 3'b000;
    localparam logic [2:0] MODE_DOWN    = 3'b001;
    localparam logic [2:0] MODE_BOUNCE  = 3'b010;
    localparam logic [2:0] MODE_ROL     = 3'b011;
    localparam logic [2:0] MODE_ROR     = 3'b100;
    localparam logic [2:0] MODE_JOHNSON = 3'b101;
    localparam logic [2:0] MODE_GRAY    = 3'b110;
    localparam logic [2:0] MODE_HOLD    = 3'b111;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    // Starting value of Q when a mode is entered; caller keeps the low width bits.
    function automatic logic [31:0] seed(input logic [2:0] mode, input int width,
                                         input logic [31:0] q);
        logic [31:0] s;
        s = '0;
        case (mode)
            MODE_DOWN: s = 32'hFFFF_FFFF >> (32 - width);
            MODE_ROL:  s = 32'd1;
            MODE_ROR:  s = 32'd1 << (width - 1);
            MODE_HOLD: s = q;
            default:   s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock by DIV while enabled; tick flags the last count of each period.
module tick_prescaler #(
    parameter int DIV = 5
) (
    input  logic CLK50MHz,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Free-running 0..DIV-1 count, frozen while disabled, cleared on restart.
    always_ff @(posedge CLK50MHz) begin
        if (!RST)     cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= (cnt == LAST) ? '0 : cnt + ONE;
    end

endmodule

// File: rtl/pattern_counter_gen.sv
// Mode-selectable LED pattern generator stepping once per prescaler tick.
module pattern_counter_gen
    import pattern_gen_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK50MHz,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    output logic [WIDTH-1:0] Q,
    output logic             TICK
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [WIDTH-1:0] QMAX = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [SYNC_STAGES-1:0]      e_sh;
    logic [SYNC_STAGES-1:0][2:0] m_sh;
    logic                        esync;
    logic [2:0]                  msync;
    logic [2:0]                  mode_r;
    logic                        mode_chg;
    logic                        step;
    dir_t                        dir;
    logic [WIDTH-1:0]            bin;
    logic [WIDTH-1:0]            bin_nx;
    logic [31:0]                 seed_full;
    logic [31:0]                 gray_full;

    assign esync     = e_sh[SYNC_STAGES-1];
    assign msync     = m_sh[SYNC_STAGES-1];
    assign mode_chg  = (msync != mode_r);
    assign bin_nx    = bin + ONE;
    assign seed_full = seed(msync, WIDTH, 32'(Q));
    assign gray_full = gray(32'(bin_nx));

    // Synchronise the slide switches into the clock domain.
    always_ff @(posedge CLK50MHz) begin
        if (!RST) begin
            e_sh <= '0;
            m_sh <= '0;
        end else begin
            e_sh <= {e_sh[SYNC_STAGES-2:0], EN};
            m_sh <= {m_sh[SYNC_STAGES-2:0], MODE};
        end
    end

    tick_prescaler #(.DIV(DIV)) u_presc (
        .CLK50MHz (CLK50MHz),
        .RST      (RST),
        .en       (esync),
        .clr      (mode_chg),
        .tick     (step)
    );

    // Mode change reseeds and suppresses the step; otherwise advance on each tick.
    always_ff @(posedge CLK50MHz) begin
        if (!RST) begin
            Q      <= '0;
            TICK   <= 1'b0;
            dir    <= DIR_UP;
            bin    <= '0;
            mode_r <= MODE_UP;
        end else if (mode_chg) begin
            mode_r <= msync;
            Q      <= seed_full[WIDTH-1:0];
            bin    <= '0;
            dir    <= DIR_UP;
            TICK   <= 1'b0;
        end else begin
            TICK <= step;
            if (step) begin
                case (mode_r)
                    MODE_UP:   Q <= Q + ONE;
                    MODE_DOWN: Q <= Q - ONE;
                    MODE_BOUNCE: begin
                        if (dir == DIR_UP) begin
                            if (Q == QMAX) begin
                                Q   <= Q - ONE;
                                dir <= DIR_DOWN;
                            end else begin
                                Q <= Q + ONE;
                            end
                        end else begin
                            if (Q == '0) begin
                                Q   <= ONE;
                                dir <= DIR_UP;
                            end else begin
                                Q <= Q - ONE;
                            end
                        end
                    end
                    MODE_ROL:     Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                    MODE_ROR:     Q <= {Q[0], Q[WIDTH-1:1]};
                    MODE_JOHNSON: Q <= {Q[WIDTH-2:0], ~Q[WIDTH-1]};
                    MODE_GRAY: begin
                        bin <= bin_nx;
                        Q   <= gray_full[WIDTH-1:0];
                    end
                    default: Q <= Q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_counter_gen.sv
// Directed bench for pattern_counter_gen at WIDTH=5, DIV=5.
module tb_pattern_counter_gen;
    localparam int W = 5;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b1;
    logic [2:0]   mode  = 3'b000;
    logic [W-1:0] q;
    logic         tick;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #10 clk = ~clk;

    pattern_counter_gen #(
        .WIDTH(W), .CLK_HZ(50), .TICK_HZ(10), .SYNC_STAGES(2)
    ) dut (
        .CLK50MHz (clk),
        .RST      (rst_n),
        .EN       (en),
        .MODE     (mode),
        .Q        (q),
        .TICK     (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until TICK is seen (bounded); n = cycles taken.
    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!tick && cnt < 20);
        chk("tick_seen", 32'(tick), 1);
    endtask

    // Change MODE and check the reseed lands on the third edge.
    task automatic set_mode(input logic [2:0] m, input int exp_seed);
        mode = m;
        repeat (3) cyc();
        chk("seed_q", 32'(q), exp_seed);
        chk("seed_tick", 32'(tick), 0);
    endtask

    int ring_exp[5] = '{2, 4, 8, 16, 1};
    int ror_exp[5]  = '{8, 4, 2, 1, 16};
    int john_exp[10] = '{1, 3, 7, 15, 31, 30, 28, 24, 16, 0};
    int gray_exp[4] = '{1, 3, 2, 6};

    initial begin
        int e;
        int n31;
        int n0;
        // 1. reset
        repeat (3) cyc();
        chk("rst_q", 32'(q), 0);
        chk("rst_tick", 32'(tick), 0);
        rst_n = 1'b1;
        wait_tick(n);
        chk("first_q", 32'(q), 1);
        cyc();
        chk("tick_one_cycle", 32'(tick), 0);

        // 2. up count, wrap, EN freeze
        for (int i = 2; i <= 32; i++) begin
            wait_tick(n);
            chk("up_q", 32'(q), i % 32);
            if (i > 2) chk("up_gap", n, 5);
        end
        for (int i = 1; i <= 9; i++) wait_tick(n);
        chk("up_q9", 32'(q), 9);
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("frz_q", 32'(q), 9);
            chk("frz_tick", 32'(tick), 0);
        end
        en = 1'b1;
        wait_tick(n);
        chk("resume_q", 32'(q), 10);

        // 3. bounce
        set_mode(3'b010, 0);
        n31 = 0;
        n0  = 0;
        for (int k = 1; k <= 63; k++) begin
            wait_tick(n);
            e = (k <= 31) ? k : ((k <= 62) ? 62 - k : k - 62);
            chk("bounce_q", 32'(q), e);
            if (k <= 62 && q == 31) n31++;
            if (k <= 62 && q == 0)  n0++;
        end
        chk("bounce_n31", n31, 1);
        chk("bounce_n0", n0, 1);

        // 4. ring shifts
        set_mode(3'b011, 1);
        for (int i = 0; i < 5; i++) begin
            wait_tick(n);
            chk("rol_q", 32'(q), ring_exp[i]);
        end
        set_mode(3'b100, 16);
        for (int i = 0; i < 5; i++) begin
            wait_tick(n);
            chk("ror_q", 32'(q), ror_exp[i]);
        end

        // 5. Johnson and Gray
        set_mode(3'b101, 0);
        for (int i = 0; i < 10; i++) begin
            wait_tick(n);
            chk("john_q", 32'(q), john_exp[i]);
        end
        set_mode(3'b110, 0);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            chk("gray_q", 32'(q), gray_exp[i]);
        end

        // 6. mode change mid-count
        set_mode(3'b000, 0);
        for (int i = 0; i < 7; i++) wait_tick(n);
        chk("mc_q7", 32'(q), 7);
        cyc();
        mode = 3'b100;
        cyc();
        chk("mc_edge1", 32'(q), 7);
        cyc();
        chk("mc_edge2", 32'(q), 7);
        cyc();
        chk("mc_edge3", 32'(q), 16);
        chk("mc_tick", 32'(tick), 0);
        wait_tick(n);
        chk("mc_gap", n, 5);
        chk("mc_next", 32'(q), 8);

        // hold
        set_mode(3'b111, 8);
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            chk("hold_gap", n, 5);
            chk("hold_q", 32'(q), 8);
        end

        // mode change while disabled
        en = 1'b0;
        set_mode(3'b001, 31);
        en = 1'b1;
        wait_tick(n);
        chk("down_q", 32'(q), 30);

        // reset mid-pattern
        wait_tick(n);
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("midrst_q", 32'(q), 0);
        chk("midrst_tick", 32'(tick), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
